// File: rtl/sophon_pkg.sv
// -----------------------------------------------------------------------------
// sophon_pkg
// Shared types and constants for the SOPHON core slice.
//   loader_state_e : states of the external-port image loader
//   LOADER_ADDR_W  : address width of the loader's ext_* request port
// -----------------------------------------------------------------------------
package sophon_pkg;

  localparam int LOADER_ADDR_W = 32;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_WRITE = 3'd1,
    LD_READ  = 3'd2,
    LD_NEXT  = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERROR = 3'd5
  } loader_state_e;

endpackage

// File: rtl/sophon_loader_wdt.sv
// -----------------------------------------------------------------------------
// sophon_loader_wdt
// Ack-wait counter for the external-port loader. Counts cycles while a
// request is outstanding and flags expiry on the ACK_TIMEOUT-th cycle.
// Only instantiated for ACK_TIMEOUT != 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (entry into a new request)
//   en         : a request is outstanding this cycle
//   expired    : this is the last allowed cycle of the request
// -----------------------------------------------------------------------------
module sophon_loader_wdt #(
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Count values 0 .. ACK_TIMEOUT-1 must be representable.
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds 0 in the first request cycle, so LIMIT is reached on
  // the ACK_TIMEOUT-th cycle of the request.
  assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/sophon_ext_loader.sv
// -----------------------------------------------------------------------------
// sophon_ext_loader
// Front-door image loader for the SOPHON ext TCM port. Takes address/data
// words from a host-side source, writes each through the ext_* port and
// holds the core in reset (core_rst_no low) until the image is loaded.
// Optional feature macro: SOPHON_LOADER_VERIFY_EN -- read back every word
// after writing it and count mismatches.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   src_valid_i/ready_o : source word handshake (addr, data, last)
//   ext_req_o .. wdata  : registered request to the core's ext port
//   ext_ack_i/error_i   : single-cycle completion, error and rdata with ack
//   core_rst_no         : core reset, released once the image is loaded
//   load_done_o         : image loaded (bus-error free)
//   load_err_o          : sticky error (bus, timeout, misalign, mismatch)
//   word_cnt_o          : words written (saturating)
//   mismatch_cnt_o      : verify mismatches (saturating, 0 without verify)
// Source handshake: a word transfers on a rising clk edge where
// src_valid_i and src_ready_o are both 1; ext request: ext_req_o is a level
// held with stable address/data until an ext_ack_i with ext_req_o = 1
// completes it, and is only withdrawn early on timeout.
// -----------------------------------------------------------------------------
module sophon_ext_loader
  import sophon_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     src_valid_i,
  output logic                     src_ready_o,
  input  logic [LOADER_ADDR_W-1:0] src_addr_i,
  input  logic [31:0]              src_data_i,
  input  logic                     src_last_i,
  output logic                     ext_req_o,
  output logic                     ext_we_o,
  output logic [LOADER_ADDR_W-1:0] ext_addr_o,
  output logic [31:0]              ext_wdata_o,
  input  logic                     ext_ack_i,
  input  logic                     ext_error_i,
  input  logic [31:0]              ext_rdata_i,
  output logic                     core_rst_no,
  output logic                     load_done_o,
  output logic                     load_err_o,
  output logic [CNT_W-1:0]         word_cnt_o,
  output logic [CNT_W-1:0]         mismatch_cnt_o
);

  loader_state_e state_q, state_d;

  logic                     ready_q, req_q, we_q, done_q, crst_q, err_q;
  logic [LOADER_ADDR_W-1:0] addr_q;
  logic [31:0]              data_q;
  logic                     last_q;
  logic [CNT_W-1:0]         word_cnt_q;

  logic hs;
  logic ack_ok;
  logic word_inc;
  logic wdt_clr, wdt_en, wdt_expired;

  // Acks arriving while no request is outstanding are ignored.
  assign ack_ok = ext_ack_i && req_q;
  assign hs     = src_valid_i && ready_q && (state_q == LD_IDLE);

`ifdef SOPHON_LOADER_VERIFY_EN
  logic             mis_inc;
  logic [CNT_W-1:0] mis_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    word_inc = 1'b0;
`ifdef SOPHON_LOADER_VERIFY_EN
    mis_inc  = 1'b0;
`endif
    case (state_q)
      LD_IDLE: begin
        if (hs) begin
          state_d = (src_addr_i[1:0] != 2'b00) ? LD_ERROR : LD_WRITE;
        end
      end
      LD_WRITE: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (ack_ok) begin
          if (ext_error_i) begin
            state_d = LD_ERROR;
          end else begin
            word_inc = 1'b1;
`ifdef SOPHON_LOADER_VERIFY_EN
            state_d  = LD_READ;
`else
            state_d  = LD_NEXT;
`endif
          end
        end else if (wdt_expired) begin
          state_d = LD_ERROR;
        end
      end
`ifdef SOPHON_LOADER_VERIFY_EN
      LD_READ: begin
        if (ack_ok) begin
          if (ext_error_i) begin
            state_d = LD_ERROR;
          end else begin
            mis_inc = (ext_rdata_i != data_q);
            state_d = LD_NEXT;
          end
        end else if (wdt_expired) begin
          state_d = LD_ERROR;
        end
      end
`endif
      LD_NEXT:  state_d = last_q ? LD_DONE : LD_IDLE;
      LD_DONE:  state_d = LD_DONE;
      LD_ERROR: state_d = LD_ERROR;
      default:  state_d = LD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from state_d so they
  // take effect in the same cycle the new state does.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      ready_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      crst_q     <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LD_IDLE);
      req_q   <= (state_d == LD_WRITE) || (state_d == LD_READ);
      we_q    <= (state_d == LD_WRITE);
      done_q  <= (state_d == LD_DONE);
      crst_q  <= (state_d == LD_DONE);
      if (hs) begin
        addr_q <= src_addr_i;
        data_q <= src_data_i;
        last_q <= src_last_i;
      end
      if (word_inc && (word_cnt_q != '1)) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
`ifdef SOPHON_LOADER_VERIFY_EN
      err_q <= err_q || (state_d == LD_ERROR) || mis_inc;
`else
      err_q <= err_q || (state_d == LD_ERROR);
`endif
    end
  end

`ifdef SOPHON_LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q <= '0;
    end else if (mis_inc && (mis_cnt_q != '1)) begin
      mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end
  assign mismatch_cnt_o = mis_cnt_q;
`else
  logic unused_rdata;
  assign unused_rdata   = ^ext_rdata_i;
  assign mismatch_cnt_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // Ack-wait watchdog: restarts on every entry to WRITE or READ, including
  // the back-to-back WRITE -> READ transition.
  // ---------------------------------------------------------------------------
  assign wdt_en  = (state_q == LD_WRITE) || (state_q == LD_READ);
  assign wdt_clr = (state_d != state_q) &&
                   ((state_d == LD_WRITE) || (state_d == LD_READ));

  generate
    if (ACK_TIMEOUT != 0) begin : g_wdt
      sophon_loader_wdt #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
      ) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdt_clr),
        .en     (wdt_en),
        .expired(wdt_expired)
      );
    end else begin : g_no_wdt
      logic unused_wdt;
      assign unused_wdt  = wdt_clr ^ wdt_en;
      assign wdt_expired = 1'b0;
    end
  endgenerate

  assign src_ready_o = ready_q;
  assign ext_req_o   = req_q;
  assign ext_we_o    = we_q;
  assign ext_addr_o  = addr_q;
  assign ext_wdata_o = data_q;
  assign core_rst_no = crst_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_sophon_ext_loader.sv
// -----------------------------------------------------------------------------
// tb_sophon_ext_loader
// Directed bench for sophon_ext_loader (ACK_TIMEOUT = 8). A responder models
// the core's ext port with programmable ack latency, error injection and
// readback corruption; expected writes sit in exp_q and are popped in order.
// -----------------------------------------------------------------------------
module tb_sophon_ext_loader;

  localparam int CNT_W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             src_valid_i = 1'b0;
  logic             src_ready_o;
  logic [31:0]      src_addr_i  = '0;
  logic [31:0]      src_data_i  = '0;
  logic             src_last_i  = 1'b0;
  logic             ext_req_o;
  logic             ext_we_o;
  logic [31:0]      ext_addr_o;
  logic [31:0]      ext_wdata_o;
  logic             ext_ack_i   = 1'b0;
  logic             ext_error_i = 1'b0;
  logic [31:0]      ext_rdata_i = '0;
  logic             core_rst_no;
  logic             load_done_o;
  logic             load_err_o;
  logic [CNT_W-1:0] word_cnt_o;
  logic [CNT_W-1:0] mismatch_cnt_o;

  sophon_ext_loader #(
    .ACK_TIMEOUT(8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid_i   (src_valid_i),
    .src_ready_o   (src_ready_o),
    .src_addr_i    (src_addr_i),
    .src_data_i    (src_data_i),
    .src_last_i    (src_last_i),
    .ext_req_o     (ext_req_o),
    .ext_we_o      (ext_we_o),
    .ext_addr_o    (ext_addr_o),
    .ext_wdata_o   (ext_wdata_o),
    .ext_ack_i     (ext_ack_i),
    .ext_error_i   (ext_error_i),
    .ext_rdata_i   (ext_rdata_i),
    .core_rst_no   (core_rst_no),
    .load_done_o   (load_done_o),
    .load_err_o    (load_err_o),
    .word_cnt_o    (word_cnt_o),
    .mismatch_cnt_o(mismatch_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];   // {addr, data} of expected writes, in order

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Ext-port responder (drives on negedge, DUT samples on posedge)
  // ---------------------------------------------------------------------------
  logic        resp_en     = 1'b1;
  int          ack_lat     = 2;
  logic        err_next    = 1'b0;
  logic        rd_bad      = 1'b0;
  logic [31:0] rd_bad_addr = '0;
  logic [31:0] last_waddr  = '0;
  logic [31:0] last_wdata  = '0;
  int          last_ack_cyc = 0;
  int          wcnt = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      ext_ack_i   = 1'b0;
      ext_error_i = 1'b0;
      wcnt        = 0;
    end else if (ext_ack_i) begin
      ext_ack_i   = 1'b0;
      ext_error_i = 1'b0;
      wcnt        = 0;
    end else if (resp_en && ext_req_o) begin
      if (wcnt >= ack_lat) begin
        ext_ack_i    = 1'b1;
        ext_error_i  = err_next;
        last_ack_cyc = cyc;
        if (ext_we_o) begin
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {32'd0, ext_addr_o}, {32'd0, e[63:32]});
            chk("wr_data", {32'd0, ext_wdata_o}, {32'd0, e[31:0]});
            last_waddr = e[63:32];
            last_wdata = e[31:0];
          end
        end else begin
          chk("rd_addr", {32'd0, ext_addr_o}, {32'd0, last_waddr});
          ext_rdata_i = (rd_bad && (last_waddr == rd_bad_addr)) ? 32'hDEADBEEF : last_wdata;
        end
      end else begin
        wcnt++;
      end
    end
  end

  int   req_rises = 0;
  logic req_prev  = 1'b0;
  always @(negedge clk) begin
    if (ext_req_o && !req_prev) req_rises++;
    req_prev = ext_req_o;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst_n       = 1'b0;
    src_valid_i = 1'b0;
    src_last_i  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                           input logic l, input logic exp_req);
    int n = 0;
    src_valid_i = 1'b1;
    src_addr_i  = a;
    src_data_i  = d;
    src_last_i  = l;
    while (!src_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("src_ready_wait", 64'd0, 64'd1);
    @(negedge clk);
    src_valid_i = 1'b0;
    chk("req_after_hs", {63'd0, ext_req_o}, {63'd0, exp_req});
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(load_done_o || load_err_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_end_budget", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int rise_cyc;
    int r0;

    // Reset values
    @(negedge clk);
    chk("rst_ready",   {63'd0, src_ready_o}, 64'd0);
    chk("rst_req",     {63'd0, ext_req_o},   64'd0);
    chk("rst_we",      {63'd0, ext_we_o},    64'd0);
    chk("rst_addr",    {32'd0, ext_addr_o},  64'd0);
    chk("rst_wdata",   {32'd0, ext_wdata_o}, 64'd0);
    chk("rst_core",    {63'd0, core_rst_no}, 64'd0);
    chk("rst_done",    {63'd0, load_done_o}, 64'd0);
    chk("rst_err",     {63'd0, load_err_o},  64'd0);
    chk("rst_wcnt",    {48'd0, word_cnt_o},  64'd0);
    chk("rst_mcnt",    {48'd0, mismatch_cnt_o}, 64'd0);
    do_reset();
    chk("ready_at_release", {63'd0, src_ready_o}, 64'd0);
    @(negedge clk);
    chk("ready_after_release", {63'd0, src_ready_o}, 64'd1);

    // Two-word load, ack latency 2
    ack_lat = 2;
    exp_q.push_back({32'h8000_0000, 32'h0000_0093});
    exp_q.push_back({32'h8000_0004, 32'h0010_0073});
    send_word(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b1);
    send_word(32'h8000_0004, 32'h0010_0073, 1'b1, 1'b1);
    n = 0;
    while (!core_rst_no && n < 100) begin
      @(negedge clk);
      n++;
    end
    rise_cyc = cyc;
    chk("two_core_rise", {63'd0, core_rst_no}, 64'd1);
    chk("two_rise_cycle", 64'(rise_cyc), 64'(last_ack_cyc + 2));
    chk("two_done",  {63'd0, load_done_o}, 64'd1);
    chk("two_err",   {63'd0, load_err_o},  64'd0);
    chk("two_wcnt",  {48'd0, word_cnt_o},  64'd2);
    chk("two_mcnt",  {48'd0, mismatch_cnt_o}, 64'd0);
    chk("two_ready", {63'd0, src_ready_o}, 64'd0);
    chk("two_req",   {63'd0, ext_req_o},   64'd0);
    chk("two_expq",  64'(exp_q.size()),    64'd0);

    // Single word, ack in the same cycle the request rises
    do_reset();
    ack_lat = 0;
    exp_q.push_back({32'h8000_0100, 32'hCAFE_F00D});
    send_word(32'h8000_0100, 32'hCAFE_F00D, 1'b1, 1'b1);
    wait_end(50);
    chk("lat0_done", {63'd0, load_done_o}, 64'd1);
    chk("lat0_err",  {63'd0, load_err_o},  64'd0);
    chk("lat0_wcnt", {48'd0, word_cnt_o},  64'd1);

    // Bus error on the first write ack
    do_reset();
    ack_lat  = 1;
    err_next = 1'b1;
    exp_q.push_back({32'h8000_0000, 32'h0000_0093});
    send_word(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b1);
    wait_end(50);
    err_next = 1'b0;
    @(negedge clk);
    chk("berr_err",   {63'd0, load_err_o},  64'd1);
    chk("berr_core",  {63'd0, core_rst_no}, 64'd0);
    chk("berr_ready", {63'd0, src_ready_o}, 64'd0);
    chk("berr_done",  {63'd0, load_done_o}, 64'd0);
    chk("berr_wcnt",  {48'd0, word_cnt_o},  64'd0);
    chk("berr_req",   {63'd0, ext_req_o},   64'd0);

    // Timeout: no ack at all, request must last exactly 8 cycles
    do_reset();
    resp_en = 1'b0;
    send_word(32'h8000_0010, 32'h1234_5678, 1'b1, 1'b1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ext_req_o) n++;
      else break;
    end
    chk("tmo_req_cycles", 64'(n), 64'd8);
    chk("tmo_err",  {63'd0, load_err_o},  64'd1);
    chk("tmo_done", {63'd0, load_done_o}, 64'd0);
    chk("tmo_core", {63'd0, core_rst_no}, 64'd0);
    resp_en = 1'b1;

`ifdef SOPHON_LOADER_VERIFY_EN
    // Verify mismatch on the first word; load still completes
    do_reset();
    ack_lat     = 1;
    rd_bad      = 1'b1;
    rd_bad_addr = 32'h8000_0000;
    exp_q.push_back({32'h8000_0000, 32'h0000_0093});
    exp_q.push_back({32'h8000_0004, 32'h0010_0073});
    send_word(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b1);
    send_word(32'h8000_0004, 32'h0010_0073, 1'b1, 1'b1);
    n = 0;
    while (!load_done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    rd_bad = 1'b0;
    chk("vfy_mcnt", {48'd0, mismatch_cnt_o}, 64'd1);
    chk("vfy_err",  {63'd0, load_err_o},     64'd1);
    chk("vfy_done", {63'd0, load_done_o},    64'd1);
    chk("vfy_core", {63'd0, core_rst_no},    64'd1);
    chk("vfy_wcnt", {48'd0, word_cnt_o},     64'd2);
`endif

    // Misaligned address: straight to ERROR without any request
    do_reset();
    r0 = req_rises;
    send_word(32'h8000_0002, 32'h0000_0013, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("mis_req_rises", 64'(req_rises), 64'(r0));
    chk("mis_err",   {63'd0, load_err_o},  64'd1);
    chk("mis_core",  {63'd0, core_rst_no}, 64'd0);
    chk("mis_ready", {63'd0, src_ready_o}, 64'd0);
    chk("mis_wcnt",  {48'd0, word_cnt_o},  64'd0);

    // Reset in the middle of an outstanding write
    do_reset();
    resp_en = 1'b0;
    send_word(32'h8000_0020, 32'h0000_0011, 1'b1, 1'b1);
    @(negedge clk);
    chk("mid_req_before", {63'd0, ext_req_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_req",   {63'd0, ext_req_o},   64'd0);
    chk("mid_we",    {63'd0, ext_we_o},    64'd0);
    chk("mid_addr",  {32'd0, ext_addr_o},  64'd0);
    chk("mid_wdata", {32'd0, ext_wdata_o}, 64'd0);
    chk("mid_core",  {63'd0, core_rst_no}, 64'd0);
    chk("mid_ready", {63'd0, src_ready_o}, 64'd0);
    resp_en = 1'b1;
    ack_lat = 1;
    do_reset();
    exp_q.push_back({32'h8000_0040, 32'h0000_0073});
    send_word(32'h8000_0040, 32'h0000_0073, 1'b1, 1'b1);
    wait_end(50);
    chk("fresh_done", {63'd0, load_done_o}, 64'd1);
    chk("fresh_err",  {63'd0, load_err_o},  64'd0);
    chk("fresh_wcnt", {48'd0, word_cnt_o},  64'd1);
    @(negedge clk);
    chk("fresh_core", {63'd0, core_rst_no}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
